// File: rtl/gpi_event_unit.sv
// gpi_event_unit: 8-bit GPI synchronizer, per-bit debounce and sticky edge-event flags.
// Build option: define GPI_IRQ_EN to drive irq from the pending flags; otherwise irq is tied 0 (polled operation).
module gpi_event_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] gpi,
  input  logic [7:0] rise_mask,
  input  logic [7:0] fall_mask,
  input  logic [7:0] evt_clr,
  output logic [7:0] gpi_level,
  output logic [7:0] evt_pending,
  output logic [7:0] evt_overflow,
  output logic       irq
);

  localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_TGT  = CW'(DEBOUNCE_CYCLES);

  logic [7:0]          r_s1;
  logic [7:0]          r_s2;
  logic [7:0]          r_level;
  logic [7:0][CW-1:0]  r_cnt;
  logic [7:0]          r_pend;
  logic [7:0]          r_ovf;

  logic [7:0][CW-1:0]  w_cnt_nxt;
  logic [7:0][CW-1:0]  w_cnt_inc;
  logic [7:0]          w_level_nxt;
  logic [7:0]          w_evt;
  logic [7:0]          w_pend_nxt;
  logic [7:0]          w_ovf_nxt;

  // Debounce counters, level acceptance and event flag next-state.
  // A clear strobe wins over old flags but never swallows an event landing on the same edge.
  always_comb begin
    w_cnt_nxt   = '0;
    w_cnt_inc   = '0;
    w_level_nxt = r_level;
    w_evt       = 8'h00;
    w_pend_nxt  = r_pend;
    w_ovf_nxt   = r_ovf;
    for (int i = 0; i < 8; i++) begin
      w_cnt_inc[i] = r_cnt[i] + CNT_ONE;
      if (r_s2[i] == r_level[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (w_cnt_inc[i] == CNT_TGT) begin
        w_cnt_nxt[i]   = '0;
        w_level_nxt[i] = r_s2[i];
        w_evt[i]       = r_s2[i] ? rise_mask[i] : fall_mask[i];
      end else begin
        w_cnt_nxt[i] = w_cnt_inc[i];
      end

      if (evt_clr[i]) begin
        w_pend_nxt[i] = w_evt[i];
        w_ovf_nxt[i]  = 1'b0;
      end else begin
        w_pend_nxt[i] = r_pend[i] | w_evt[i];
        w_ovf_nxt[i]  = r_ovf[i] | (w_evt[i] & r_pend[i]);
      end
    end
  end

  // Synchronizer, debounce state and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 8'h00;
      r_s2    <= 8'h00;
      r_level <= 8'h00;
      r_cnt   <= '0;
      r_pend  <= 8'h00;
      r_ovf   <= 8'h00;
    end else begin
      r_s1    <= gpi;
      r_s2    <= r_s1;
      r_level <= w_level_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign gpi_level    = r_level;
  assign evt_pending  = r_pend;
  assign evt_overflow = r_ovf;

`ifdef GPI_IRQ_EN
  logic r_irq;

  // Interrupt register tracks the next pending state so it rises on the same edge as the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |w_pend_nxt;
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_gpi_event_unit.sv
// Scoreboard bench for gpi_event_unit with DEBOUNCE_CYCLES=4; expectations are queued as stimulus is applied.
module tb_gpi_event_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gpi;
  logic [7:0] rise_mask;
  logic [7:0] fall_mask;
  logic [7:0] evt_clr;
  logic [7:0] gpi_level;
  logic [7:0] evt_pending;
  logic [7:0] evt_overflow;
  logic       irq;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [24:0] v;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [24:0] obs;

  gpi_event_unit #(.DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .gpi          (gpi),
    .rise_mask    (rise_mask),
    .fall_mask    (fall_mask),
    .evt_clr      (evt_clr),
    .gpi_level    (gpi_level),
    .evt_pending  (evt_pending),
    .evt_overflow (evt_overflow),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  assign obs = {gpi_level, evt_pending, evt_overflow, irq};

  function automatic logic exp_irq(input logic [7:0] pend);
`ifdef GPI_IRQ_EN
    return |pend;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [24:0] pack(input logic [7:0] lvl, input logic [7:0] pend, input logic [7:0] ovf);
    return {lvl, pend, ovf, exp_irq(pend)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; gpi = 8'h00; rise_mask = 8'h00; fall_mask = 8'h00; evt_clr = 8'h00;
    sb.push_back('{"reset", pack(8'h00, 8'h00, 8'h00)});
    repeat (3) tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    rst = 1'b0;
  endtask

  task automatic test_rise_latency();
    rise_mask = 8'h01; fall_mask = 8'h00; gpi = 8'h01;
    sb.push_back('{"lat_edge4", pack(8'h00, 8'h00, 8'h00)});
    repeat (5) tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    sb.push_back('{"lat_edge5", pack(8'h01, 8'h01, 8'h00)});
    tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
  endtask

  task automatic test_glitch();
    rise_mask = 8'h03; gpi = 8'h03;
    repeat (3) tick();
    gpi = 8'h01;
    sb.push_back('{"glitch", pack(8'h01, 8'h01, 8'h00)});
    repeat (8) tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
  endtask

  task automatic test_overflow();
    gpi = 8'h00;
    sb.push_back('{"ovf_fall", pack(8'h00, 8'h01, 8'h00)});
    repeat (6) tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    gpi = 8'h01;
    sb.push_back('{"ovf_rise", pack(8'h01, 8'h01, 8'h01)});
    repeat (6) tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    evt_clr = 8'h01;
    sb.push_back('{"ovf_clr", pack(8'h01, 8'h00, 8'h00)});
    tick();
    evt_clr = 8'h00;
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
  endtask

  task automatic test_clr_coincide();
    fall_mask = 8'h01; gpi = 8'h00;
    sb.push_back('{"cc_fall", pack(8'h00, 8'h01, 8'h00)});
    repeat (6) tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    gpi = 8'h01;
    sb.push_back('{"cc_pre", pack(8'h00, 8'h01, 8'h00)});
    repeat (5) tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    evt_clr = 8'h01;
    sb.push_back('{"cc_clr", pack(8'h01, 8'h01, 8'h00)});
    tick();
    evt_clr = 8'h00;
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
  endtask

  task automatic test_mask_change();
    rise_mask = 8'h00; fall_mask = 8'hFF;
    sb.push_back('{"mask", pack(8'h01, 8'h01, 8'h00)});
    repeat (3) tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
  endtask

  task automatic test_fall();
    evt_clr = 8'hFF;
    tick();
    evt_clr = 8'h00; fall_mask = 8'h02; rise_mask = 8'h00; gpi = 8'h03;
    sb.push_back('{"fall_hi", pack(8'h03, 8'h00, 8'h00)});
    repeat (6) tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    gpi = 8'h01;
    sb.push_back('{"fall_lo", pack(8'h01, 8'h02, 8'h00)});
    repeat (6) tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
  endtask

  task automatic test_reset_mid();
    rise_mask = 8'hA5; fall_mask = 8'h00; gpi = 8'hFF;
    repeat (4) tick();
    rst = 1'b1;
    sb.push_back('{"rst_mid", pack(8'h00, 8'h00, 8'h00)});
    repeat (2) tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    rst = 1'b0;
    sb.push_back('{"rst_edge4", pack(8'h00, 8'h00, 8'h00)});
    repeat (5) tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    sb.push_back('{"rst_edge5", pack(8'hFF, 8'hA5, 8'h00)});
    tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin failures++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
  endtask

  initial begin
    test_reset();
    test_rise_latency();
    test_glitch();
    test_overflow();
    test_clr_coincide();
    test_mask_change();
    test_fall();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
